// File: rtl/core_pkg.sv
// Shared constants for the core's memory bus: word width, MMIO page layout and boot PC.
package core_pkg;

  localparam int          WORD_W    = 16;
  localparam logic [15:0] MMIO_BASE = 16'hFF00;
  localparam logic [15:0] BOOT_PC   = 16'h0100;

  localparam logic [7:0] MMIO_CYCLE  = 8'd0;
  localparam logic [7:0] MMIO_LEDS   = 8'd1;
  localparam logic [7:0] MMIO_WRCNT  = 8'd2;
  localparam logic [7:0] MMIO_ERRCLR = 8'd3;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_NONE
  } region_t;

endpackage

// File: rtl/sync_ram.sv
// Single-port RAM with one write port and a registered read, shaped to map onto block RAM.
module sync_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    if (re)
      q <= mem[addr];
  end

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder: decodes CPU word accesses into RAM / MMIO / unmapped and
// services host preload writes into RAM whenever the CPU bus is idle.
module ram_responder #(
  parameter int          ADDR_W    = 12,
  parameter logic [15:0] MMIO_BASE = core_pkg::MMIO_BASE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [core_pkg::WORD_W-1:0] addr,
  input  logic [core_pkg::WORD_W-1:0] wdata,
  input  logic                        read_en,
  input  logic                        write_en,
  output logic [core_pkg::WORD_W-1:0] rdata,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [core_pkg::WORD_W-1:0] load_addr,
  input  logic [core_pkg::WORD_W-1:0] load_data,
  output logic [7:0]                  leds,
  output logic                        bus_err
);

  localparam int W = core_pkg::WORD_W;

  logic             req, cpu_rd, cpu_wr;
  logic             ram_hit, mmio_hit, load_hit, load_fire;
  logic             ram_we, ram_re, err_set, err_clr;
  logic [W-1:0]     mmio_off, mmio_val, rd_hold, ram_q, cycle_cnt, wr_cnt;
  logic [7:0]       reg_sel;
  core_pkg::region_t region, rd_region;

  assign req        = read_en | write_en;
  assign cpu_wr     = write_en & ~rst;
  assign cpu_rd     = read_en & ~write_en & ~rst;
  assign ram_hit    = (addr[W-1:ADDR_W] == '0);
  assign mmio_off   = addr - MMIO_BASE;
  assign mmio_hit   = (addr >= MMIO_BASE) && (mmio_off[W-1:8] == '0);
  assign reg_sel    = mmio_off[7:0];
  assign load_ready = ~req & ~rst;
  assign load_fire  = load_valid & load_ready;
  assign load_hit   = (load_addr[W-1:ADDR_W] == '0);

  always_comb begin
    region = core_pkg::REGION_NONE;
    if (ram_hit)
      region = core_pkg::REGION_RAM;
    else if (mmio_hit)
      region = core_pkg::REGION_MMIO;
  end

  // CYCLE and WRCNT reads see the pre-increment register value of the sampling edge.
  always_comb begin
    mmio_val = '0;
    case (reg_sel)
      core_pkg::MMIO_CYCLE: mmio_val = cycle_cnt;
      core_pkg::MMIO_LEDS:  mmio_val = {8'h00, leds};
      core_pkg::MMIO_WRCNT: mmio_val = wr_cnt;
      default:              mmio_val = '0;
    endcase
  end

  assign ram_we  = (cpu_wr && region == core_pkg::REGION_RAM) || (load_fire && load_hit);
  assign ram_re  = cpu_rd && region == core_pkg::REGION_RAM;
  assign err_set = ((cpu_rd || cpu_wr) && region == core_pkg::REGION_NONE) ||
                   (load_fire && !load_hit);
  assign err_clr = cpu_wr && region == core_pkg::REGION_MMIO && reg_sel == core_pkg::MMIO_ERRCLR;

  // The CPU owns the single RAM port whenever it has a request; preloads use idle cycles.
  sync_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (req ? addr[ADDR_W-1:0] : load_addr[ADDR_W-1:0]),
    .wdata(req ? wdata : load_data),
    .q    (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      wr_cnt    <= '0;
      leds      <= '0;
      bus_err   <= 1'b0;
      rd_region <= core_pkg::REGION_NONE;
      rd_hold   <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (cpu_wr && region == core_pkg::REGION_RAM)
        wr_cnt <= wr_cnt + 1'b1;
      if (cpu_wr && region == core_pkg::REGION_MMIO && reg_sel == core_pkg::MMIO_LEDS)
        leds <= wdata[7:0];
      if (err_set)
        bus_err <= 1'b1;
      else if (err_clr)
        bus_err <= 1'b0;
      // Region is registered with the RAM read so the output mux lines up with ram_q.
      if (cpu_rd) begin
        rd_region <= region;
        rd_hold   <= (region == core_pkg::REGION_MMIO) ? mmio_val : '0;
      end
    end
  end

  assign rdata = (rd_region == core_pkg::REGION_RAM) ? ram_q : rd_hold;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: reads push expected data, a monitor pops and compares.
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = '0, wdata = '0, load_addr = '0, load_data = '0;
  logic        read_en = 1'b0, write_en = 1'b0, load_valid = 1'b0;
  logic [15:0] rdata;
  logic        load_ready, bus_err;
  logic [7:0]  leds;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cyc = '0;
  logic [15:0] c1, c2;

  ram_responder #(.ADDR_W(12), .MMIO_BASE(16'hFF00)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wdata     (wdata),
    .read_en   (read_en),
    .write_en  (write_en),
    .rdata     (rdata),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_addr (load_addr),
    .load_data (load_data),
    .leds      (leds),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  // Reference cycle counter: value a CYCLE read issued before the next edge should return.
  always @(posedge clk) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 16'd1;
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] a,
                               input logic [15:0] d, input logic [15:0] exp);
    read_en  = rd;
    write_en = wr;
    addr     = a;
    wdata    = d;
    if (rd && !wr && !rst) exp_q.push_back(exp);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    read_en  = 1'b0;
    write_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    #1 checkOutput("load_ready_idle", {15'd0, load_ready}, 16'd1);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Monitor: a read sampled on a rising edge presents data by the following falling edge.
  initial begin
    logic seen;
    forever begin
      @(posedge clk);
      seen = read_en && !write_en && !rst;
      if (seen) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL rdata: got %h expected no read", rdata);
        end else begin
          checkOutput("rdata", rdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_rdata", rdata, 16'h0000);
    checkOutput("reset_leds", {8'h00, leds}, 16'h0000);
    checkOutput("reset_bus_err", {15'd0, bus_err}, 16'h0000);
    checkOutput("reset_load_ready", {15'd0, load_ready}, 16'h0000);
    rst = 1'b0;

    // Preload boot image, then read it back
    preload(16'h0100, 16'h1234);
    preload(16'h0101, 16'hBEEF);
    checkOutput("load_keeps_rdata", rdata, 16'h0000);
    applyStimulus(1, 0, 16'h0100, 16'h0, 16'h1234);
    applyStimulus(1, 0, 16'h0101, 16'h0, 16'hBEEF);

    // Write then read, hold across idle, write counter
    applyStimulus(0, 1, 16'h0200, 16'hA5A5, 16'h0);
    applyStimulus(1, 0, 16'h0200, 16'h0, 16'hA5A5);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      checkOutput("rdata_hold", rdata, 16'hA5A5);
    end
    applyStimulus(1, 0, 16'hFF02, 16'h0, 16'h0001);

    // Preload stalls behind CPU reads
    load_valid = 1'b1;
    load_addr  = 16'h0102;
    load_data  = 16'h5555;
    for (int i = 0; i < 2; i++) begin
      read_en  = 1'b1;
      write_en = 1'b0;
      addr     = 16'h0100;
      exp_q.push_back(16'h1234);
      #1 checkOutput("load_stall", {15'd0, load_ready}, 16'd0);
      @(negedge clk);
    end
    read_en = 1'b0;
    #1 checkOutput("load_resume", {15'd0, load_ready}, 16'd1);
    @(negedge clk);
    load_valid = 1'b0;
    checkOutput("rdata_after_load", rdata, 16'h1234);
    applyStimulus(1, 0, 16'h0102, 16'h0, 16'h5555);

    // MMIO LEDs and cycle counter
    applyStimulus(0, 1, 16'hFF01, 16'h00C3, 16'h0);
    checkOutput("leds", {8'h00, leds}, 16'h00C3);
    applyStimulus(1, 0, 16'hFF01, 16'h0, 16'h00C3);
    applyStimulus(1, 0, 16'hFF00, 16'h0, cyc);
    c1 = rdata;
    idle(4);
    applyStimulus(1, 0, 16'hFF00, 16'h0, cyc);
    c2 = rdata;
    checkOutput("cycle_delta", c2 - c1, 16'd5);
    applyStimulus(0, 1, 16'hFF00, 16'hDEAD, 16'h0);
    applyStimulus(1, 0, 16'hFF02, 16'h0, 16'h0001);

    // Unmapped access, sticky error, clear
    applyStimulus(1, 0, 16'h8000, 16'h0, 16'h0000);
    checkOutput("bus_err_set", {15'd0, bus_err}, 16'd1);
    idle(2);
    checkOutput("bus_err_sticky", {15'd0, bus_err}, 16'd1);
    applyStimulus(0, 1, 16'hFF03, 16'h0, 16'h0);
    checkOutput("bus_err_clear", {15'd0, bus_err}, 16'd0);
    idle(1);
    preload(16'h9000, 16'h7777);
    checkOutput("load_unmapped_err", {15'd0, bus_err}, 16'd1);
    applyStimulus(0, 1, 16'hFF03, 16'h0, 16'h0);
    checkOutput("bus_err_clear2", {15'd0, bus_err}, 16'd0);

    // Reset during a write
    applyStimulus(0, 1, 16'h0300, 16'h1111, 16'h0);
    applyStimulus(1, 0, 16'h8000, 16'h0, 16'h0000);
    applyStimulus(1, 0, 16'h0300, 16'h0, 16'h1111);
    rst = 1'b1;
    applyStimulus(0, 1, 16'h0300, 16'h2222, 16'h0);
    rst = 1'b0;
    checkOutput("rst_rdata", rdata, 16'h0000);
    checkOutput("rst_leds", {8'h00, leds}, 16'h0000);
    checkOutput("rst_bus_err", {15'd0, bus_err}, 16'd0);
    applyStimulus(1, 0, 16'hFF02, 16'h0, 16'h0000);
    applyStimulus(1, 0, 16'h0300, 16'h0, 16'h1111);
    applyStimulus(1, 0, 16'hFF00, 16'h0, cyc);
    idle(1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard_drained", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
